// File: rtl/md_unit_arbiter_if.sv
// Bus between two requesters, the shared multiply/divide unit and the arbiter.
// Handshakes: req_n stays high until gnt_n, and an operation is accepted in the cycle where req_n and gnt_n are both high.
// rvalid_n is a one-cycle result pulse with no backpressure, and u_start is a one-cycle launch.
// The unit answers with a one-cycle u_finished.
interface md_unit_arbiter_if #(
  parameter int WORD_SIZE = 32
);
  logic                 req_0;
  logic                 req_1;
  logic [WORD_SIZE-1:0] op_a_0;
  logic [WORD_SIZE-1:0] op_b_0;
  logic [WORD_SIZE-1:0] op_a_1;
  logic [WORD_SIZE-1:0] op_b_1;
  logic [2:0]           func_0;
  logic [2:0]           func_1;
  logic [1:0]           sign_0;
  logic [1:0]           sign_1;
  logic                 flush_0;
  logic                 flush_1;
  logic                 gnt_0;
  logic                 gnt_1;
  logic                 busy_0;
  logic                 busy_1;
  logic                 rvalid_0;
  logic                 rvalid_1;
  logic [WORD_SIZE-1:0] rdata;
  logic                 u_start;
  logic [WORD_SIZE-1:0] u_op_a;
  logic [WORD_SIZE-1:0] u_op_b;
  logic [2:0]           u_func;
  logic [1:0]           u_sign;
  logic                 u_finished;
  logic [WORD_SIZE-1:0] u_result;

  modport master (
    output req_0, req_1, op_a_0, op_b_0, op_a_1, op_b_1,
           func_0, func_1, sign_0, sign_1, flush_0, flush_1,
           u_finished, u_result,
    input  gnt_0, gnt_1, busy_0, busy_1, rvalid_0, rvalid_1, rdata,
           u_start, u_op_a, u_op_b, u_func, u_sign
  );

  modport slave (
    input  req_0, req_1, op_a_0, op_b_0, op_a_1, op_b_1,
           func_0, func_1, sign_0, sign_1, flush_0, flush_1,
           u_finished, u_result,
    output gnt_0, gnt_1, busy_0, busy_1, rvalid_0, rvalid_1, rdata,
           u_start, u_op_a, u_op_b, u_func, u_sign
  );
endinterface

// File: rtl/md_unit_arbiter.sv
// Round-robin arbiter sharing one multi-cycle mul/div unit between two requesters,
// with per-requester flush that drains an abandoned operation.
module md_unit_arbiter #(
  parameter int WORD_SIZE  = 32,
  parameter int FIRST_PRIO = 0
) (
  input  logic               CLK,
  input  logic               RST,
  md_unit_arbiter_if.slave   bus,
  output logic [2:0]         state_dbg
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  state_t               state;
  logic                 owner;
  logic                 last_grant;
  logic [WORD_SIZE-1:0] lat_a;
  logic [WORD_SIZE-1:0] lat_b;
  logic [2:0]           lat_func;
  logic [1:0]           lat_sign;
  logic [WORD_SIZE-1:0] rdata_q;

  logic any_req;
  logic pick_1;
  logic grant_en;
  logic flush_own;
  logic active;
  logic result_ok;

  always_comb begin
    any_req   = bus.req_0 | bus.req_1;
    // On a tie, the requester that did not complete last wins.
    pick_1    = bus.req_1 & (~bus.req_0 | ~last_grant);
    grant_en  = ~RST & (state == IDLE) & any_req;
    flush_own = owner ? bus.flush_1 : bus.flush_0;
    active    = ~RST & (state != IDLE);
    result_ok = ~RST & (state == RESP) & ~flush_own;
  end

  assign bus.gnt_0    = grant_en & ~pick_1;
  assign bus.gnt_1    = grant_en & pick_1;
  assign bus.busy_0   = active & ~owner;
  assign bus.busy_1   = active & owner;
  assign bus.rvalid_0 = result_ok & ~owner;
  assign bus.rvalid_1 = result_ok & owner;
  assign bus.rdata    = rdata_q;
  assign bus.u_start  = ~RST & (state == ISSUE);
  assign bus.u_op_a   = lat_a;
  assign bus.u_op_b   = lat_b;
  assign bus.u_func   = lat_func;
  assign bus.u_sign   = lat_sign;
  assign state_dbg    = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= (FIRST_PRIO == 0) ? 1'b1 : 1'b0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_func   <= '0;
      lat_sign   <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= pick_1;
            lat_a    <= pick_1 ? bus.op_a_1 : bus.op_a_0;
            lat_b    <= pick_1 ? bus.op_b_1 : bus.op_b_0;
            lat_func <= pick_1 ? bus.func_1 : bus.func_0;
            lat_sign <= pick_1 ? bus.sign_1 : bus.sign_0;
            state    <= ISSUE;
          end
        end
        ISSUE: state <= flush_own ? DRAIN : WAIT;
        WAIT: begin
          if (bus.u_finished) begin
            if (flush_own) begin
              last_grant <= owner;
              state      <= IDLE;
            end else begin
              rdata_q <= bus.u_result;
              state   <= RESP;
            end
          end else if (flush_own) begin
            state <= DRAIN;
          end
        end
        RESP: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        DRAIN: begin
          // The unit cannot be aborted, so wait for it and throw the result away.
          if (bus.u_finished) begin
            last_grant <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_unit_arbiter.sv
// Bench for md_unit_arbiter: directed scenarios plus randomized rounds, checked
// against a transaction-level model of grant order, timing and results.
module tb_md_unit_arbiter;
  localparam int W          = 32;
  localparam int FIRST_PRIO = 0;

  // clock / reset
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] state_dbg;
  always #5 CLK = ~CLK;

  md_unit_arbiter_if #(.WORD_SIZE(W)) bus();

  md_unit_arbiter #(.WORD_SIZE(W), .FIRST_PRIO(FIRST_PRIO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int             prio_next;
  logic [W-1:0]   exp_rdata;
  logic [W:0]     exp_q[$];
  logic [W-1:0]   op_a[2];
  logic [W-1:0]   op_b[2];
  logic [2:0]     fn[2];
  logic [1:0]     sg[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic gnt_of(input int n);
    return (n == 0) ? bus.gnt_0 : bus.gnt_1;
  endfunction
  function automatic logic busy_of(input int n);
    return (n == 0) ? bus.busy_0 : bus.busy_1;
  endfunction
  function automatic logic rvalid_of(input int n);
    return (n == 0) ? bus.rvalid_0 : bus.rvalid_1;
  endfunction

  // scoreboard: every result pulse must match the oldest expected result
  logic [W:0] sb_e;
  always @(negedge CLK) begin
    if (!RST && (bus.rvalid_0 || bus.rvalid_1)) begin
      check("rvalid_onehot", bus.rvalid_0 & bus.rvalid_1, 1'b0);
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 1'b1, 1'b0);
      end else begin
        sb_e = exp_q.pop_front();
        check("rvalid_who", bus.rvalid_1, sb_e[W]);
        check("rdata", bus.rdata, sb_e[W-1:0]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_0 = 1'b0;  bus.req_1 = 1'b0;
    bus.flush_0 = 1'b0; bus.flush_1 = 1'b0;
    bus.u_finished = 1'b0;
  endtask

  task automatic set_flush(input int own, input logic f_own, input logic f_oth);
    if (own == 0) begin bus.flush_0 = f_own; bus.flush_1 = f_oth; end
    else          begin bus.flush_1 = f_own; bus.flush_0 = f_oth; end
  endtask

  task automatic rand_ops();
    logic [2:0] one;
    int s;
    one = 3'b001;
    for (int i = 0; i < 2; i++) begin
      op_a[i] = $urandom();
      op_b[i] = $urandom();
      fn[i]   = one << $urandom_range(0, 2);
      s       = $urandom_range(0, 2);
      sg[i]   = (s == 0) ? 2'b00 : ((s == 1) ? 2'b10 : 2'b11);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},    {bus.gnt_0, bus.gnt_1}, 2'b00);
    check({tag, "_busy"},   {bus.busy_0, bus.busy_1}, 2'b00);
    check({tag, "_rvalid"}, {bus.rvalid_0, bus.rvalid_1}, 2'b00);
    check({tag, "_start"},  bus.u_start, 1'b0);
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    tick();
    @(negedge CLK);
    check_quiet("reset");
    check("reset_rdata", bus.rdata, '0);
    check("reset_u_op_a", bus.u_op_a, '0);
    tick();
    RST = 1'b0;
    prio_next = FIRST_PRIO;
    exp_rdata = '0;
  endtask

  // One operation. mode: 0 normal, 1 flush in ISSUE, 2 flush early in WAIT,
  // 3 flush together with u_finished, 4 flush during the result cycle.
  task automatic do_op(input bit r0, input bit r1, input int mode, input int k,
                       input bit spur, input logic [W-1:0] res);
    int w;
    int o;
    bit fo;
    logic wb;
    w  = (r0 && r1) ? prio_next : (r0 ? 0 : 1);
    o  = 1 - w;
    wb = (w == 1);
    // request cycle (IDLE)
    bus.req_0 = r0; bus.req_1 = r1;
    bus.op_a_0 = op_a[0]; bus.op_b_0 = op_b[0]; bus.func_0 = fn[0]; bus.sign_0 = sg[0];
    bus.op_a_1 = op_a[1]; bus.op_b_1 = op_b[1]; bus.func_1 = fn[1]; bus.sign_1 = sg[1];
    bus.u_finished = spur;
    bus.u_result   = $urandom();
    bus.flush_0 = 1'($urandom_range(0, 1));
    bus.flush_1 = 1'($urandom_range(0, 1));
    @(negedge CLK);
    check("gnt_winner", gnt_of(w), 1'b1);
    check("gnt_loser",  gnt_of(o), 1'b0);
    check("idle_busy",  {bus.busy_0, bus.busy_1}, 2'b00);
    check("idle_start", bus.u_start, 1'b0);
    tick();
    // issue cycle: requester inputs change, latched copies must not
    bus.req_0 = 1'b0; bus.req_1 = 1'b0;
    if (o == 0) bus.req_0 = 1'($urandom_range(0, 1)); else bus.req_1 = 1'($urandom_range(0, 1));
    bus.op_a_0 = $urandom(); bus.op_a_1 = $urandom();
    bus.op_b_0 = $urandom(); bus.op_b_1 = $urandom();
    bus.u_finished = spur;
    fo = 1'($urandom_range(0, 1));
    set_flush(w, mode == 1, fo);
    @(negedge CLK);
    check("issue_start", bus.u_start, 1'b1);
    check("issue_op_a",  bus.u_op_a, op_a[w]);
    check("issue_op_b",  bus.u_op_b, op_b[w]);
    check("issue_func",  bus.u_func, fn[w]);
    check("issue_sign",  bus.u_sign, sg[w]);
    check("issue_busy",  {busy_of(w), busy_of(o)}, 2'b10);
    check("issue_gnt",   {bus.gnt_0, bus.gnt_1}, 2'b00);
    tick();
    // unit latency cycles
    for (int c = 1; c <= k; c++) begin
      bus.u_finished = (c == k);
      bus.u_result   = res;
      fo = 1'($urandom_range(0, 1));
      set_flush(w, (mode == 2 && c == 1) || (mode == 3 && c == k), fo);
      @(negedge CLK);
      check("wait_busy",   {busy_of(w), busy_of(o)}, 2'b10);
      check("wait_start",  bus.u_start, 1'b0);
      check("wait_rvalid", {bus.rvalid_0, bus.rvalid_1}, 2'b00);
      check("wait_gnt",    {bus.gnt_0, bus.gnt_1}, 2'b00);
      check("wait_op_a",   bus.u_op_a, op_a[w]);
      check("wait_func",   bus.u_func, fn[w]);
      tick();
    end
    // result cycle for modes 0/4, already idle for the flushed modes
    bus.req_0 = 1'b0; bus.req_1 = 1'b0;
    bus.u_finished = 1'b0;
    bus.u_result   = $urandom();
    fo = 1'($urandom_range(0, 1));
    set_flush(w, mode == 4, fo);
    if (mode == 0) exp_q.push_back({wb, res});
    if (mode == 0 || mode == 4) exp_rdata = res;
    @(negedge CLK);
    if (mode == 0 || mode == 4) begin
      check("resp_busy",   {busy_of(w), busy_of(o)}, 2'b10);
      check("resp_rvalid", {rvalid_of(w), rvalid_of(o)}, (mode == 0) ? 2'b10 : 2'b00);
    end else begin
      check("flushed_busy",   {bus.busy_0, bus.busy_1}, 2'b00);
      check("flushed_rvalid", {bus.rvalid_0, bus.rvalid_1}, 2'b00);
    end
    check("rdata_hold", bus.rdata, exp_rdata);
    tick();
    idle_inputs();
    prio_next = o;
  endtask

  task automatic reset_mid_op();
    rand_ops();
    bus.req_0 = 1'b1;
    bus.op_a_0 = op_a[0]; bus.op_b_0 = op_b[0]; bus.func_0 = fn[0]; bus.sign_0 = sg[0];
    @(negedge CLK);
    check("rst_op_gnt", bus.gnt_0, 1'b1);
    tick();
    bus.req_0 = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    bus.req_0 = 1'b1;
    @(negedge CLK);
    check_quiet("rst_during");
    tick();
    RST = 1'b0;
    bus.req_0 = 1'b0;
    bus.u_finished = 1'b1;
    bus.u_result   = $urandom();
    @(negedge CLK);
    check_quiet("rst_stray");
    check("rst_rdata",  bus.rdata, '0);
    check("rst_u_op_a", bus.u_op_a, '0);
    check("rst_u_op_b", bus.u_op_b, '0);
    tick();
    bus.u_finished = 1'b0;
    @(negedge CLK);
    check_quiet("rst_after");
    tick();
    prio_next = FIRST_PRIO;
    exp_rdata = '0;
  endtask

  initial begin
    int r0;
    int r1;
    int mode;
    int k;
    idle_inputs();
    bus.u_result = '0;
    bus.op_a_0 = '0; bus.op_b_0 = '0; bus.func_0 = '0; bus.sign_0 = '0;
    bus.op_a_1 = '0; bus.op_b_1 = '0; bus.func_1 = '0; bus.sign_1 = '0;
    prio_next = FIRST_PRIO;
    exp_rdata = '0;
    tick();
    do_reset();

    // single signed multiply, 7 * -3, unit latency 3, spurious finish in IDLE/ISSUE
    op_a[0] = 32'd7; op_b[0] = 32'hFFFF_FFFD; fn[0] = 3'b100; sg[0] = 2'b11;
    op_a[1] = '0;    op_b[1] = '0;            fn[1] = 3'b010; sg[1] = 2'b00;
    do_op(1'b1, 1'b0, 0, 3, 1'b1, 32'hFFFF_FFEB);

    // contention from reset alternates 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      do_op(1'b1, 1'b1, 0, $urandom_range(1, 4), 1'b0, $urandom());
    end

    // requester 1 divide flushed in WAIT, then a tie must go to 0
    rand_ops();
    fn[1] = 3'b010;
    do_op(1'b0, 1'b1, 2, 3, 1'b0, $urandom());
    rand_ops();
    do_op(1'b1, 1'b1, 0, 2, 1'b0, $urandom());

    // flush in the same cycle as u_finished
    rand_ops();
    do_op(1'b0, 1'b1, 3, 2, 1'b0, $urandom());

    // reset mid-operation, then normal service
    reset_mid_op();
    rand_ops();
    do_op(1'b1, 1'b0, 0, 1, 1'b1, $urandom());

    // randomized rounds
    for (int i = 0; i < 60; i++) begin
      rand_ops();
      r0 = $urandom_range(0, 1);
      r1 = (r0 == 0) ? 1 : $urandom_range(0, 1);
      mode = $urandom_range(0, 4);
      k = (mode == 2) ? $urandom_range(2, 5) : $urandom_range(1, 5);
      do_op(r0 != 0, r1 != 0, mode, k, 1'($urandom_range(0, 1)), $urandom());
    end

    @(negedge CLK);
    check("results_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
